// File: rtl/pc_pkg.sv
// pc_pkg: shared states, next-PC selects and trap cause codes for the PC sequencer.
package pc_pkg;
  typedef enum logic {RUN, HALT} state_t;
  typedef enum logic [2:0] {SEL_SEQ, SEL_BR, SEL_JALR, SEL_TRAP, SEL_MRET, SEL_HOLD} sel_t;
  localparam logic [3:0] CAUSE_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
  localparam logic [3:0] CAUSE_BREAK      = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;
endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: prioritised next-PC selection with misaligned-target detection.
module pc_next_mux
  import pc_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] TRAP_VEC = 'h100
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] epc,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jalr,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            trap_req,
  input  logic [3:0]      trap_cause,
  input  logic            mret,
  input  logic            halt_req,
  output sel_t            sel,
  output logic [XLEN-1:0] next_pc,
  output logic [3:0]      cause
);
  logic [XLEN-1:0] jalr_masked;
  logic            misaligned;
  assign jalr_masked = jalr_target & ~{{(XLEN-1){1'b0}}, 1'b1};
  // Either redirect pointing off a word boundary traps, even if a higher-priority jump is aligned.
  assign misaligned = (jalr && jalr_masked[1]) || (br_taken && |br_target[1:0]);
  always_comb begin
    sel = (trap_req || misaligned) ? SEL_TRAP :
          mret     ? SEL_MRET :
          jalr     ? SEL_JALR :
          br_taken ? SEL_BR   :
          halt_req ? SEL_HOLD : SEL_SEQ;
    next_pc = (sel == SEL_TRAP) ? TRAP_VEC    :
              (sel == SEL_MRET) ? epc         :
              (sel == SEL_JALR) ? jalr_masked :
              (sel == SEL_BR)   ? br_target   :
              (sel == SEL_HOLD) ? pc          : pc_plus4;
    cause = trap_req ? trap_cause : CAUSE_MISALIGNED;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with redirect, trap/mret, stall, halt/resume and retire counter.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = 'h100,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [XLEN-1:0]  br_target,
  input  logic             jalr,
  input  logic [XLEN-1:0]  jalr_target,
  input  logic             trap_req,
  input  logic [3:0]       trap_cause,
  input  logic             mret,
  input  logic             halt_req,
  input  logic             resume,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic [XLEN-1:0]  epc,
  output logic [3:0]       mcause,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);
  state_t          state, state_nxt;
  sel_t            sel;
  logic [XLEN-1:0] next_pc;
  logic [3:0]      cause;
  assign pc_plus4 = pc + XLEN'(4);
  assign halted   = (state == HALT);
  pc_next_mux #(.XLEN(XLEN), .TRAP_VEC(TRAP_VEC)) u_mux (
    .pc(pc), .pc_plus4(pc_plus4), .epc(epc),
    .br_taken(br_taken), .br_target(br_target),
    .jalr(jalr), .jalr_target(jalr_target),
    .trap_req(trap_req), .trap_cause(trap_cause),
    .mret(mret), .halt_req(halt_req),
    .sel(sel), .next_pc(next_pc), .cause(cause)
  );
  always_comb begin
    state_nxt = (state == HALT) ? (resume ? RUN : HALT) :
                (!stall && sel == SEL_HOLD) ? HALT : RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end
  // Resume steps past the ebreak without counting it as retired.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_VEC;
      epc     <= '0;
      mcause  <= '0;
      retired <= '0;
    end else if (state == HALT) begin
      if (resume) pc <= pc_plus4;
    end else if (!stall) begin
      pc <= next_pc;
      if (sel == SEL_TRAP) begin
        epc    <= pc;
        mcause <= cause;
      end
      if (sel != SEL_TRAP && sel != SEL_HOLD) retired <= retired + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plan plus random stimulus, scoreboarded against a behavioural PC model.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        reset, stall, br_taken, jalr, trap_req, mret, halt_req, resume;
  logic [31:0] br_target, jalr_target;
  logic [3:0]  trap_cause;
  logic [31:0] pc, pc_plus4, epc, retired;
  logic [3:0]  mcause;
  logic        halted;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [3:0]  cause;
    logic        halted;
    logic [31:0] retired;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int checks = 0;
  int errors = 0;
  logic done = 1'b0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jalr(jalr), .jalr_target(jalr_target),
    .trap_req(trap_req), .trap_cause(trap_cause),
    .mret(mret), .halt_req(halt_req), .resume(resume),
    .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .mcause(mcause),
    .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  // Reference model: architectural effect of one clock edge given the current inputs.
  task automatic model_step();
    logic [31:0] jt;
    bit mis;
    if (reset) begin
      m.pc = 32'h0; m.epc = 0; m.cause = 0; m.halted = 0; m.retired = 0;
    end else if (m.halted) begin
      if (resume) begin
        m.pc = m.pc + 32'd4;
        m.halted = 0;
      end
    end else if (!stall) begin
      jt  = {jalr_target[31:1], 1'b0};
      mis = (jalr && (jt % 4 != 0)) || (br_taken && (br_target % 4 != 0));
      if (trap_req || mis) begin
        m.epc   = m.pc;
        m.cause = trap_req ? trap_cause : 4'd0;
        m.pc    = 32'h100;
      end else if (!mret && !jalr && !br_taken && halt_req) begin
        m.halted = 1;
      end else begin
        m.retired = m.retired + 1;
        if (mret)          m.pc = m.epc;
        else if (jalr)     m.pc = jt;
        else if (br_taken) m.pc = br_target;
        else               m.pc = m.pc + 32'd4;
      end
    end
  endtask

  task automatic tick();
    model_step();
    q.push_back(m);
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 0; stall = 0; br_taken = 0; jalr = 0; trap_req = 0;
    mret = 0; halt_req = 0; resume = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every edge the DUT presents a new architectural state.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("pc", pc, e.pc);
      chk("pc_plus4", pc_plus4, e.pc + 32'd4);
      chk("epc", epc, e.epc);
      chk("mcause", {28'd0, mcause}, {28'd0, e.cause});
      chk("halted", {31'd0, halted}, {31'd0, e.halted});
      chk("retired", retired, e.retired);
    end
  end

  initial begin
    logic [31:0] r;
    idle();
    br_target = 0; jalr_target = 0; trap_cause = 0;
    m = '{pc: 0, epc: 0, cause: 0, halted: 0, retired: 0};
    @(negedge clk);
    reset = 1; tick(); reset = 0;
    repeat (4) tick();
    br_taken = 1; br_target = 32'h40; tick(); idle();
    jalr = 1; jalr_target = 32'h81; tick(); idle();
    br_taken = 1; br_target = 32'h20; tick();
    br_target = 32'h22; tick(); idle();
    mret = 1; tick(); idle();
    br_taken = 1; br_target = 32'h30; tick();
    trap_req = 1; trap_cause = 4'd11; br_target = 32'h44; tick(); idle();
    br_taken = 1; br_target = 32'h50; tick();
    stall = 1; br_target = 32'h70; repeat (3) tick(); idle();
    tick();
    br_taken = 1; br_target = 32'h60; tick(); idle();
    halt_req = 1; tick(); idle();
    repeat (4) tick();
    resume = 1; tick(); idle();
    br_taken = 1; br_target = 32'hFFFF_FFFC; tick(); idle();
    tick();
    mret = 1; jalr = 1; jalr_target = 32'h200; tick(); idle();
    br_taken = 1; br_target = 32'h300; jalr = 1; jalr_target = 32'h400; tick(); idle();
    halt_req = 1; tick(); idle();
    tick(); stall = 1; tick(); idle();
    reset = 1; tick(); idle();
    tick();
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom % 200) == 0;
      stall    = ($urandom % 6) == 0;
      trap_req = ($urandom % 20) == 0;
      mret     = ($urandom % 15) == 0;
      jalr     = ($urandom % 8) == 0;
      br_taken = ($urandom % 6) == 0;
      halt_req = ($urandom % 25) == 0;
      resume   = ($urandom % 4) == 0;
      trap_cause = 4'($urandom);
      r = $urandom;
      br_target = (($urandom % 8) == 0) ? r : (r & 32'hFFFF_FFFC);
      r = $urandom;
      jalr_target = (($urandom % 8) == 0) ? r : (r & 32'hFFFF_FFFD);
      tick();
    end
    idle();
    tick();
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
